sig_dump_engine: RTL and testbench

- Memory-mapped test-host responder. It snoops CPU stores to the test window at TEST_BASE (32'h20000000) and latches the signature bounds.
- On a halt store, it freezes the CPU and walks the signature region through a read port on the data memory. Each word is emitted on a valid/ready stream toward the host/bench.
- Sits in the top level beside the CPU and ram_dp. While dump_active is high, the top-level data-address mux hands the memory data port to this block.

---
 rtl/sig_dump_engine_if.sv | 27 ++
 rtl/sig_dump_engine.sv | 156 +++++++++++++++
 tb/tb_sig_dump_engine.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_dump_engine_if.sv
// Bus bundle between the signature dump engine and its CPU snoop, memory read port and host stream.
// master = engine side, slave = CPU/memory/host side.
interface sig_dump_engine_if;
    logic        store;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        halted;
    logic        dump_active;
    logic        mem_rd_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;

    modport master (
        input  store, address, store_data, mem_data, out_ready,
        output halted, dump_active, mem_rd_en, mem_addr, out_valid, out_data, out_last, done
    );

    modport slave (
        output store, address, store_data, mem_data, out_ready,
        input  halted, dump_active, mem_rd_en, mem_addr, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/sig_dump_engine.sv
// Snoops test-window stores, freezes the CPU on halt and streams the signature region out word by word.
// First beat T+3 (READ_LATENCY 1) / T+2 (0) after the halt store; each beat holds until out_ready. Macro SIG_CHECKSUM_EN appends a sum beat.
module sig_dump_engine #(
    parameter logic [31:0] TEST_BASE    = 32'h2000_0000,
    parameter int          READ_LATENCY = 1
) (
    input logic               clock,
    input logic               reset,
    sig_dump_engine_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_DONE} state_t;

    state_t      r_state;
    logic [29:0] r_sig_begin;
    logic [29:0] r_sig_end;
    logic [29:0] r_ptr;
    logic        r_halted;
    logic        r_dump_active;
    logic        r_mem_rd_en;
    logic [29:0] r_mem_addr;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_last;
    logic        r_done;
`ifdef SIG_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_csum_beat;
`endif

    logic w_st_halt;
    logic w_st_begin;
    logic w_st_end;
    logic w_empty;
    logic w_ptr_last;
    logic w_capture;

    assign w_st_halt  = bus.store && (bus.address == TEST_BASE) && (bus.store_data == 32'd1);
    assign w_st_begin = bus.store && (bus.address == TEST_BASE + 32'd4);
    assign w_st_end   = bus.store && (bus.address == TEST_BASE + 32'd8);
    assign w_empty    = (r_sig_end <= r_sig_begin);
    assign w_ptr_last = ((r_ptr + 30'd1) == r_sig_end);
    // Read data lands while in ISSUE for a combinational memory, in WAIT for a registered one.
    assign w_capture  = (r_state == S_WAIT) || ((r_state == S_ISSUE) && (READ_LATENCY == 0));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sig_begin   <= '0;
            r_sig_end     <= '0;
            r_ptr         <= '0;
            r_halted      <= 1'b0;
            r_dump_active <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_addr    <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_done        <= 1'b0;
`ifdef SIG_CHECKSUM_EN
            r_sum         <= '0;
            r_csum_beat   <= 1'b0;
`endif
        end else begin
            if (w_capture) begin
                r_state     <= S_PRESENT;
                r_out_valid <= 1'b1;
                r_out_data  <= bus.mem_data;
`ifdef SIG_CHECKSUM_EN
                r_out_last  <= 1'b0;
`else
                r_out_last  <= w_ptr_last;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (w_st_begin) r_sig_begin <= bus.store_data[31:2];
                    if (w_st_end)   r_sig_end   <= bus.store_data[31:2];
                    if (w_st_halt) begin
                        r_halted <= 1'b1;
                        r_ptr    <= r_sig_begin;
                        if (w_empty) begin
`ifdef SIG_CHECKSUM_EN
                            r_state       <= S_PRESENT;
                            r_dump_active <= 1'b1;
                            r_out_valid   <= 1'b1;
                            r_out_data    <= '0;
                            r_out_last    <= 1'b1;
                            r_csum_beat   <= 1'b1;
`else
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state       <= S_ISSUE;
                            r_dump_active <= 1'b1;
                            r_mem_rd_en   <= 1'b1;
                            r_mem_addr    <= r_sig_begin;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_rd_en <= 1'b0;
                    if (READ_LATENCY != 0) r_state <= S_WAIT;
                end
                S_WAIT: ;
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
`ifdef SIG_CHECKSUM_EN
                        if (r_csum_beat) begin
                            r_state       <= S_DONE;
                            r_dump_active <= 1'b0;
                            r_done        <= 1'b1;
                        end else if (w_ptr_last) begin
                            // Last data word accepted: present the running sum without touching memory.
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                            r_out_data  <= r_sum + r_out_data;
                            r_csum_beat <= 1'b1;
                        end else begin
                            r_sum       <= r_sum + r_out_data;
                            r_state     <= S_ISSUE;
                            r_ptr       <= r_ptr + 30'd1;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_ptr + 30'd1;
                        end
`else
                        if (w_ptr_last) begin
                            r_state       <= S_DONE;
                            r_dump_active <= 1'b0;
                            r_done        <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_ptr       <= r_ptr + 30'd1;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_ptr + 30'd1;
                        end
`endif
                    end
                end
                S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.halted      = r_halted;
    assign bus.dump_active = r_dump_active;
    assign bus.mem_rd_en   = r_mem_rd_en;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_last    = r_out_last;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_sig_dump_engine.sv
// Bench for sig_dump_engine: a reference model queues expected beats per dump, a negedge monitor compares them.
module tb_sig_dump_engine;
    localparam int          LAT     = 1;
    localparam logic [31:0] TB_BASE = 32'h2000_0000;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        csum;
    } beat_t;

    logic clock;
    logic reset;
    sig_dump_engine_if u_if ();

    sig_dump_engine #(.TEST_BASE(TB_BASE), .READ_LATENCY(LAT)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    always @(posedge clock) if (u_if.mem_rd_en) rd_q <= mem[u_if.mem_addr[9:0]];
    assign u_if.mem_data = (LAT == 1) ? rd_q : mem[u_if.mem_addr[9:0]];

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = -1;
    int popped = 0;
    int rdy_mode = 0;
    bit check_interval = 0;
    logic [29:0] reg_lo = '0;
    logic [29:0] reg_hi = '0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected dump computed straight from the region bounds and memory contents.
    task automatic push_expected(input logic [29:0] lo, input logic [29:0] hi);
        beat_t b;
        logic [31:0] sum;
        sum = '0;
        for (int w = int'(lo); w < int'(hi); w++) begin
            b.data = mem[w];
            b.csum = 1'b0;
`ifdef SIG_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (w == int'(hi) - 1);
`endif
            sum = sum + mem[w];
            exp_q.push_back(b);
        end
`ifdef SIG_CHECKSUM_EN
        b.data = sum; b.last = 1'b1; b.csum = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    always @(negedge clock) begin
        cyc++;
        if (!reset && u_if.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got=%h last=%b", u_if.out_data, u_if.out_last);
            end else begin
                if (u_if.out_data !== exp_q[0].data || u_if.out_last !== exp_q[0].last) begin
                    errors++;
                    $display("FAIL beat got=%h/%b exp=%h/%b", u_if.out_data, u_if.out_last,
                             exp_q[0].data, exp_q[0].last);
                end
                if (u_if.out_ready) begin
                    if (check_interval && !exp_q[0].csum && last_hs >= 0)
                        chk("beat_interval", 128'(cyc - last_hs), 128'(LAT + 2));
                    last_hs = cyc;
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
        if (!reset && u_if.mem_rd_en) begin
            checks++;
            if (!u_if.dump_active || u_if.mem_addr < reg_lo || u_if.mem_addr >= reg_hi) begin
                errors++;
                $display("FAIL mem_read addr=%h active=%b", u_if.mem_addr, u_if.dump_active);
            end
        end
    end

    logic rdy_tog = 1'b0;
    initial begin
        u_if.out_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            rdy_tog = ~rdy_tog;
            case (rdy_mode)
                0: u_if.out_ready = 1'b1;
                1: u_if.out_ready = rdy_tog;
                2: u_if.out_ready = 1'($urandom_range(0, 1));
                default: u_if.out_ready = (popped < 1);
            endcase
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        u_if.store = 1'b1; u_if.address = a; u_if.store_data = d;
        @(posedge clock); #1;
        u_if.store = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; u_if.store = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete(); popped = 0; last_hs = -1;
    endtask

    task automatic set_region(input logic [31:0] b, input logic [31:0] e);
        do_store(TB_BASE + 32'd4, b);
        do_store(TB_BASE + 32'd8, e);
        reg_lo = b[31:2]; reg_hi = e[31:2];
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!u_if.done && n < 2000) begin @(posedge clock); #1; n++; end
        chk("done_timeout", 128'(u_if.done), 128'(1));
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        chk("halted_sticky", 128'(u_if.halted), 128'(1));
        chk("inactive_done", 128'({u_if.dump_active, u_if.out_valid}), 128'(0));
    endtask

    task automatic run_dump(input logic [31:0] b, input logic [31:0] e, input int mode);
        do_reset();
        rdy_mode = mode; check_interval = 0;
        set_region(b, e);
        push_expected(b[31:2], e[31:2]);
        do_store(TB_BASE, 32'd1);
        do_store(TB_BASE + 32'd8, 32'h0);  // must be ignored once out of IDLE
        wait_done();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        u_if.store = 1'b0; u_if.address = '0; u_if.store_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[32'h40] = 32'hA000_000A; mem[32'h41] = 32'hB000_000B;
        mem[32'h42] = 32'hC000_000C; mem[32'h43] = 32'hD000_000D;
        mem[32'h60] = 32'hFFFF_FFFF; mem[32'h61] = 32'h0000_0002;

        do_reset();
        chk("reset_outputs", {u_if.halted, u_if.dump_active, u_if.mem_rd_en, u_if.mem_addr,
                              u_if.out_valid, u_if.out_data, u_if.out_last, u_if.done}, 128'(0));

        // Halt arriving together with reset loses.
        reset = 1'b1;
        u_if.store = 1'b1; u_if.address = TB_BASE; u_if.store_data = 32'd1;
        @(posedge clock); #1;
        u_if.store = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        chk("halt_with_reset", 128'({u_if.halted, u_if.dump_active}), 128'(0));

        // Basic dump with latency and interval checks.
        do_reset();
        rdy_mode = 0; check_interval = 1;
        set_region(32'h100, 32'h110);
        push_expected(30'h40, 30'h44);
        do_store(TB_BASE, 32'd1);
        chk("halted_set", 128'(u_if.halted), 128'(1));
        n = 0;
        while (!u_if.out_valid && n < 50) begin @(posedge clock); #1; n++; end
        chk("first_valid_latency", 128'(n + 1), 128'(LAT + 2));
        wait_done();
        check_interval = 0;

        run_dump(32'h100, 32'h110, 1);

        // Empty region.
        do_reset();
        set_region(32'h200, 32'h200);
        push_expected(30'h80, 30'h80);
        do_store(TB_BASE, 32'd1);
`ifdef SIG_CHECKSUM_EN
        chk("empty_csum_valid", 128'(u_if.out_valid), 128'(1));
`else
        chk("empty_done_next", 128'(u_if.done), 128'(1));
`endif
        wait_done();

        // Non-1 halt data is ignored.
        do_reset();
        rdy_mode = 0;
        set_region(32'h100, 32'h110);
        do_store(TB_BASE, 32'd2);
        repeat (3) @(posedge clock);
        #1 chk("halt2_ignored", 128'({u_if.halted, u_if.dump_active, u_if.mem_rd_en}), 128'(0));
        push_expected(30'h40, 30'h44);
        do_store(TB_BASE, 32'd1);
        wait_done();

        // Reset while beat 2 of 4 is presented.
        do_reset();
        rdy_mode = 3;
        set_region(32'h100, 32'h110);
        push_expected(30'h40, 30'h44);
        do_store(TB_BASE, 32'd1);
        n = 0;
        while (!(u_if.out_valid && popped == 1) && n < 100) begin @(posedge clock); #1; n++; end
        chk("beat2_reached", 128'(popped), 128'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midreset_outputs", {u_if.halted, u_if.dump_active, u_if.mem_rd_en, u_if.mem_addr,
                                 u_if.out_valid, u_if.out_data, u_if.out_last, u_if.done}, 128'(0));
        reset = 1'b0;
        exp_q.delete(); popped = 0; last_hs = -1;
        rdy_mode = 0;
        reg_lo = '0; reg_hi = '0;
        push_expected(30'h0, 30'h0);
        do_store(TB_BASE, 32'd1);
        wait_done();

        // Wrapping checksum words.
        run_dump(32'h180, 32'h188, 0);

        for (int i = 0; i < 6; i++) begin
            logic [29:0] lo, hi;
            lo = 30'($urandom_range(2, 500));
            hi = (i == 5) ? lo - 30'd2 : lo + 30'($urandom_range(0, 7));
            run_dump({lo, 2'b00}, {hi, 2'b00}, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
